// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_pkg
//   Shared definitions for the write-back stage and GPR file.
//   - wb_src_e : write-back source select encoding (matches the MEM/WB field)
//   - REG_ZERO : index of the hard-wired zero register
// -----------------------------------------------------------------------------
package wb_regfile_pkg;

    typedef enum logic [1:0] {
        WB_SRC_ALU_RESULT = 2'b00,
        WB_SRC_MEM_DATA   = 2'b01,
        WB_SRC_LINK       = 2'b10,
        WB_SRC_NONE       = 2'b11
    } wb_src_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/wb_regfile_gpr_array.sv
// -----------------------------------------------------------------------------
// wb_regfile_gpr_array
//   2-read / 1-write architectural register storage.
//   Index 0 is never written and always reads 0.
//   Optional macro REGFILE_BYPASS_EN: a read of the register being written in
//   the same cycle returns the incoming write data (write-before-read).
//   Without it, reads return the pre-write contents.
// Ports
//   clk, rst         clock / asynchronous active-high reset (clears all entries)
//   we_i             effective write enable
//   waddr_i, wdata_i write index / data
//   raddr1_i/2_i     read indices
//   rdata1_o/2_o     combinational read data
// -----------------------------------------------------------------------------
module wb_regfile_gpr_array
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_q [NREG];

    // Reset wins over a coincident clock edge, so a write presented while rst
    // is high is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (we_i && (waddr_i != ZERO_IDX)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = mem_q[raddr1_i];
        rdata2_o = mem_q[raddr2_i];
`ifdef REGFILE_BYPASS_EN
        if (we_i && (raddr1_i == waddr_i)) rdata1_o = wdata_i;
        if (we_i && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
`endif
        // Zero register override comes last so bypass can never leak into it.
        if (raddr1_i == ZERO_IDX) rdata1_o = '0;
        if (raddr2_i == ZERO_IDX) rdata2_o = '0;
    end

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Write-back stage + architectural register file (last MIPS32 pipe stage).
//   Selects the write-back value from the MEM/WB outputs, writes it to the
//   32-entry GPR array, serves the two ID read ports, exports the committed
//   write for EX forwarding and counts retired writes.
//   Optional macro REGFILE_BYPASS_EN enables same-cycle WB->ID bypass.
// Ports
//   clk, rst                 clock / asynchronous active-high reset
//   wb_mem_data              load data
//   wb_alu_result            ALU result
//   wb_link_addr             PC+8 link value
//   wb_reg_wr                write enable from MEM/WB
//   wb_waddr                 destination index
//   wb_reg_wb_src            source select (wb_src_e)
//   id_raddr1/2, id_rdata1/2 ID read ports (combinational)
//   wb_wdata, wb_we          selected value / effective write (combinational)
//   wb_retire_cnt            count of effective writes (registered, wraps)
// -----------------------------------------------------------------------------
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [DATA_W-1:0] wb_link_addr,
    input  logic              wb_reg_wr,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [1:0]        wb_reg_wb_src,
    input  logic [ADDR_W-1:0] id_raddr1,
    input  logic [ADDR_W-1:0] id_raddr2,
    output logic [DATA_W-1:0] id_rdata1,
    output logic [DATA_W-1:0] id_rdata2,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_we,
    output logic [CNT_W-1:0]  wb_retire_cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        wb_wdata = '0;
        case (wb_src_e'(wb_reg_wb_src))
            WB_SRC_ALU_RESULT: wb_wdata = wb_alu_result;
            WB_SRC_MEM_DATA:   wb_wdata = wb_mem_data;
            WB_SRC_LINK:       wb_wdata = wb_link_addr;
            default:           wb_wdata = '0;
        endcase
    end

    assign wb_we = wb_reg_wr
                && (wb_waddr != ADDR_W'(REG_ZERO))
                && (wb_src_e'(wb_reg_wb_src) != WB_SRC_NONE);

    // Free-running wrap, no overflow flag.
    always_comb begin
        cnt_d = cnt_q;
        if (wb_we) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign wb_retire_cnt = cnt_q;

    wb_regfile_gpr_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_gpr (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_we),
        .waddr_i  (wb_waddr),
        .wdata_i  (wb_wdata),
        .raddr1_i (id_raddr1),
        .raddr2_i (id_raddr2),
        .rdata1_o (id_rdata1),
        .rdata2_o (id_rdata2)
    );

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk, rst;
    logic [31:0] mem_d, alu, link;
    logic        reg_wr;
    logic [4:0]  waddr, ra1, ra2;
    logic [1:0]  src;
    logic [31:0] rd1, rd2, wdata, cnt;
    logic        we;
    // Narrow-counter instance: reaches its all-ones value in 15 writes.
    logic [31:0] n_rd1, n_rd2, n_wdata;
    logic        n_we;
    logic [3:0]  n_cnt;

    int vec = 0;
    int err = 0;

    logic [31:0] ref_gpr [32];
    logic [31:0] ref_cnt;
    logic [3:0]  ref_cnt4;

    wb_regfile dut (
        .clk(clk), .rst(rst), .wb_mem_data(mem_d), .wb_alu_result(alu),
        .wb_link_addr(link), .wb_reg_wr(reg_wr), .wb_waddr(waddr),
        .wb_reg_wb_src(src), .id_raddr1(ra1), .id_raddr2(ra2),
        .id_rdata1(rd1), .id_rdata2(rd2), .wb_wdata(wdata), .wb_we(we),
        .wb_retire_cnt(cnt)
    );

    wb_regfile #(.CNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .wb_mem_data(mem_d), .wb_alu_result(alu),
        .wb_link_addr(link), .wb_reg_wr(reg_wr), .wb_waddr(waddr),
        .wb_reg_wb_src(src), .id_raddr1(ra1), .id_raddr2(ra2),
        .id_rdata1(n_rd1), .id_rdata2(n_rd2), .wb_wdata(n_wdata), .wb_we(n_we),
        .wb_retire_cnt(n_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_wdata();
        case (src)
            2'd0:    return alu;
            2'd1:    return mem_d;
            2'd2:    return link;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_we();
        return reg_wr && (waddr != 0) && (src != 2'd3);
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (m_we() && a == waddr) return m_wdata();
`endif
        return ref_gpr[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
        ref_cnt  = 32'h0;
        ref_cnt4 = 4'h0;
    endtask

    task automatic drive(input logic rw, input logic [4:0] wa, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] m, input logic [31:0] l,
                         input logic [4:0] r1, input logic [4:0] r2);
        reg_wr = rw; waddr = wa; src = s; alu = a; mem_d = m; link = l;
        ra1 = r1; ra2 = r2;
        #1;
    endtask

    // Advance one clock edge, applying the model's write if rst is low.
    task automatic tick();
        logic        w;
        logic [4:0]  wa;
        logic [31:0] wd;
        w = m_we(); wa = waddr; wd = m_wdata();
        @(posedge clk);
        if (w && !rst) begin
            ref_gpr[wa] = wd;
            ref_cnt++;
            ref_cnt4++;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        model_clear();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            vec++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                err++;
                $display("FAIL reset_read idx=%0d got %h/%h want 0/0", i, rd1, rd2);
            end
        end
        vec++;
        if (cnt !== 32'h0) begin
            err++;
            $display("FAIL reset_cnt got %h want 0", cnt);
        end
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_writes();
        drive(1, 5, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0);
        vec++;
        if (wdata !== 32'hDEADBEEF || we !== 1'b1) begin
            err++;
            $display("FAIL wr_alu_comb got %h/%b want deadbeef/1", wdata, we);
        end
        tick();
        drive(1, 6, 2'd1, 32'h0, 32'h12345678, 32'h0, 5, 0);
        vec++;
        if (rd1 !== 32'hDEADBEEF || cnt !== 32'd1) begin
            err++;
            $display("FAIL wr_alu got %h cnt %0d want deadbeef cnt 1", rd1, cnt);
        end
        tick();
        drive(1, 31, 2'd2, 32'h0, 32'h0, 32'h00400008, 6, 0);
        vec++;
        if (rd1 !== 32'h12345678 || cnt !== 32'd2) begin
            err++;
            $display("FAIL wr_mem got %h cnt %0d want 12345678 cnt 2", rd1, cnt);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 31, 5);
        vec++;
        if (rd1 !== 32'h00400008 || rd2 !== 32'hDEADBEEF || cnt !== 32'd3) begin
            err++;
            $display("FAIL wr_link got %h/%h cnt %0d want 00400008/deadbeef cnt 3", rd1, rd2, cnt);
        end
    endtask

    task automatic test_suppressed();
        logic [31:0] c0;
        c0 = cnt;
        // waddr 0, src none, reg_wr 0
        drive(1, 0, 2'd0, 32'hFFFFFFFF, 0, 0, 0, 0);
        vec++;
        if (we !== 1'b0) begin err++; $display("FAIL sup_zero_we got %b want 0", we); end
        tick();
        drive(1, 7, 2'd3, 32'hCAFE0007, 32'hCAFE0007, 32'hCAFE0007, 0, 0);
        vec++;
        if (rd1 !== 32'h0 || we !== 1'b0 || wdata !== 32'h0) begin
            err++;
            $display("FAIL sup_none got rd0=%h we=%b wd=%h want 0/0/0", rd1, we, wdata);
        end
        tick();
        drive(0, 8, 2'd0, 32'hCAFE0008, 0, 0, 7, 8);
        vec++;
        if (we !== 1'b0 || rd1 !== 32'h0) begin
            err++;
            $display("FAIL sup_rw0 got we=%b r7=%h want 0/0", we, rd1);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 8, 0);
        vec++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0 || cnt !== c0) begin
            err++;
            $display("FAIL sup_state got r8=%h r0=%h cnt=%0d want 0/0/%0d", rd1, rd2, cnt, c0);
        end
    endtask

    task automatic test_hazard();
        logic [31:0] exp;
        drive(1, 9, 2'd0, 32'h11111111, 0, 0, 0, 0);
        tick();
        drive(1, 9, 2'd0, 32'hA5A5A5A5, 0, 0, 9, 9);
`ifdef REGFILE_BYPASS_EN
        exp = 32'hA5A5A5A5;
`else
        exp = 32'h11111111;
`endif
        vec++;
        if (rd1 !== exp || rd2 !== exp) begin
            err++;
            $display("FAIL hazard_same got %h/%h want %h", rd1, rd2, exp);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 9, 9);
        vec++;
        if (rd1 !== 32'hA5A5A5A5 || rd2 !== 32'hA5A5A5A5) begin
            err++;
            $display("FAIL hazard_next got %h/%h want a5a5a5a5", rd1, rd2);
        end
    endtask

    task automatic test_random();
        logic [4:0] wa;
        for (int n = 0; n < 300; n++) begin
            wa = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 3) != 0), wa, 2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
            vec++;
            if (wdata !== m_wdata() || we !== m_we() || rd1 !== m_rd(ra1) || rd2 !== m_rd(ra2)) begin
                err++;
                $display("FAIL rand_comb n=%0d got wd=%h we=%b r1=%h r2=%h want %h %b %h %h",
                         n, wdata, we, rd1, rd2, m_wdata(), m_we(), m_rd(ra1), m_rd(ra2));
            end
            vec++;
            if (n_wdata !== m_wdata() || n_we !== m_we() || n_rd1 !== m_rd(ra1) || n_rd2 !== m_rd(ra2)) begin
                err++;
                $display("FAIL rand_narrow n=%0d got wd=%h we=%b r1=%h r2=%h", n, n_wdata, n_we, n_rd1, n_rd2);
            end
            tick();
            vec++;
            if (cnt !== ref_cnt || n_cnt !== ref_cnt4) begin
                err++;
                $display("FAIL rand_cnt n=%0d got %0d/%0d want %0d/%0d", n, cnt, n_cnt, ref_cnt, ref_cnt4);
            end
        end
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 16 && ref_cnt4 != 4'hF; n++) begin
            drive(1, 5'($urandom_range(1, 31)), 2'd0, $urandom, 0, 0, 0, 0);
            tick();
        end
        vec++;
        if (n_cnt !== 4'hF) begin
            err++;
            $display("FAIL wrap_pre got %h want f", n_cnt);
        end
        drive(1, 3, 2'd1, 0, 32'h0BADF00D, 0, 0, 0);
        tick();
        vec++;
        if (n_cnt !== 4'h0 || cnt !== ref_cnt) begin
            err++;
            $display("FAIL wrap got %h cnt=%0d want 0 cnt=%0d", n_cnt, cnt, ref_cnt);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 10, 2'd0, 32'h55, 0, 0, 0, 0);
        tick();
        drive(1, 11, 2'd0, 32'h77, 0, 0, 10, 0);
        vec++;
        if (rd1 !== 32'h55) begin err++; $display("FAIL rmid_pre got %h want 55", rd1); end
        @(negedge clk);
        rst = 1;
        #1;
        model_clear();
        vec++;
        if (rd1 !== 32'h0 || cnt !== 32'h0 || n_cnt !== 4'h0) begin
            err++;
            $display("FAIL rmid_async got r10=%h cnt=%0d/%0d want 0", rd1, cnt, n_cnt);
        end
        @(posedge clk); #1;  // write to 11 presented on this edge under reset
        drive(0, 0, 0, 0, 0, 0, 11, 10);
        vec++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0 || cnt !== 32'h0) begin
            err++;
            $display("FAIL rmid_drop got r11=%h r10=%h cnt=%0d want 0", rd1, rd2, cnt);
        end
        @(negedge clk);
        rst = 0;
        drive(1, 12, 2'd2, 0, 0, 32'h99, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 12, 11);
        vec++;
        if (rd1 !== 32'h99 || rd2 !== 32'h0 || cnt !== 32'd1 || n_cnt !== 4'd1) begin
            err++;
            $display("FAIL rmid_first got r12=%h r11=%h cnt=%0d/%0d want 99/0/1/1", rd1, rd2, cnt, n_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_writes();
        test_suppressed();
        test_hazard();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
